acia_rx_ovs: RTL and testbench
==============================

// Module: acia_rx_ovs
// PURPOSE
//  Parametrised ACIA receiver: oversampled async serial in, 3-sample majority vote at mid-bit,
//  5..8-bit words, optional parity, break detection, FIFO of received chars with per-entry status.
//  Sits between the RX pin and the ACIA register file; single clock domain (BCLK).
// PARAMETERS
//  OVERSAMPLE   16  BCLK ticks per bit; even, >=8
//  FIFO_DEPTH   4   entries; power of 2, >=2
//  SYNC_STAGES  2   RX input synchroniser flops, >=2
// PORTS
//  BCLK      in   1   oversample clock; all logic posedge
//  RESET     in   1   asynchronous, active-low
//  RX        in   1   serial line, idle high
//  R_WL      in   2   word length: 00=8, 01=7, 10=6, 11=5 bits
//  R_PME     in   1   1 = parity bit present
//  R_PMC     in   2   00 odd, 01 even, 1x parity bit received but not checked
//  RXPOP     in   1   1-cycle strobe: discard head entry
//  RXDATA    out  8   head data, right-justified, unused MSBs 0
//  RXFRAME   out  1   head entry framing error
//  RXPARITY  out  1   head entry parity error
//  RXBREAK   out  1   head entry is a break
//  RXEMPTY   out  1   FIFO empty
//  RXFULL    out  1   FIFO full
//  RXCOUNT   out  $clog2(FIFO_DEPTH+1)  entries held
//  OVERFLOW  out  1   sticky: a completed frame was dropped
//  RXACTIVE  out  1   FSM not in IDLE/BRKWAIT
// BEHAVIOUR
//  Reset: all outputs 0 except RXEMPTY=1; synchroniser flops reset to 1; FSM=IDLE; FIFO cleared.
//  Reset mid-frame aborts the frame; nothing pushed.
//  Sampling: counter 0..OVERSAMPLE-1 per bit; bit value = majority of synced RX at
//   OVERSAMPLE/2-1, /2, /2+1; bit decided at tick OVERSAMPLE/2+1.
//  FSM: IDLE -> START on synced-RX 1->0 edge (counter cleared).
//   START: voted 1 -> IDLE (glitch, nothing pushed); voted 0 -> DATA; R_WL/R_PME/R_PMC latched here,
//    held for the whole frame.
//   DATA: LSB first, N=8-R_WL bits; then PARITY if R_PME else STOP.
//   PARITY: err = (PMC=00 & ones(data+par) even) | (PMC=01 & ones odd); PMC=1x -> err=0.
//   STOP: one stop bit checked; FRAME = voted stop==0. Push at decide tick, then IDLE
//    (receiver resyncs on next edge; second stop bit never checked).
//   Break: data all 0, parity bit 0 (if present), stop 0 -> push {BREAK=1,FRAME=1,PARITY=0,data=0},
//    then BRKWAIT until synced RX=1, then IDLE. Only one entry per break regardless of length.
//  FIFO: entry {BREAK,FRAME,PARITY,data[7:0]}; show-ahead, head visible on RXDATA/flags same
//   cycle RXEMPTY=0; when empty outputs hold 0.
//   Push latency: entry visible cycle after STOP decide tick.
//   Push while full and no pop: frame dropped, OVERFLOW=1 (sticky), FIFO unchanged.
//   Push+pop same cycle when full: both succeed, no overflow; count unchanged.
//   Pop while empty: ignored. OVERFLOW cleared by any RXPOP (set wins if same cycle).
//   Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH.
// STRUCTURE
//  Package acia_pkg: WL codes, PMC codes, FSM state enum (IDLE,START,DATA,PARITY,STOP,BRKWAIT),
//   RX entry field positions/width (11).
//  Sub-module acia_fifo (generic WIDTH/DEPTH sync FIFO, show-ahead, count/full/empty) instanced
//   once; synchroniser, vote, FSM in top.
// TESTING
//  8N1, 0xA5, OVERSAMPLE=16 -> one entry 0xA5, flags 0, RXCOUNT=1; RXPOP -> RXEMPTY=1.
//  7E1 (WL=01,PME=1,PMC=01) 0x41 with wrong parity bit -> RXDATA=0x41, RXPARITY=1.
//  Low pulse 5 ticks on idle line -> no entry, RXACTIVE back to 0 within 1 bit time.
//  5N1 with stop bit 0 after data 0x15 -> RXDATA=0x15, RXFRAME=1; RX held low 3 frames -> 1 break entry.
//  Fill 4 frames, send 5th without pop -> OVERFLOW=1, RXCOUNT=4, head unchanged; pop -> OVERFLOW=0.
//  Assert RESET mid-DATA -> RXEMPTY=1, FSM IDLE; next clean frame 0x3C received correctly.

Source files
------------

// File: rtl/acia_pkg.sv
// Shared types and constants for the ACIA receive path: format codes, FSM states and
// the layout of one received-character FIFO entry.
package acia_pkg;

    localparam logic [1:0] WL_8 = 2'b00;
    localparam logic [1:0] WL_7 = 2'b01;
    localparam logic [1:0] WL_6 = 2'b10;
    localparam logic [1:0] WL_5 = 2'b11;

    localparam logic [1:0] PMC_ODD  = 2'b00;
    localparam logic [1:0] PMC_EVEN = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRKWAIT
    } rx_state_t;

    localparam int unsigned ENT_DATA_LSB = 0;
    localparam int unsigned ENT_DATA_W   = 8;
    localparam int unsigned ENT_PAR      = 8;
    localparam int unsigned ENT_FRAME    = 9;
    localparam int unsigned ENT_BRK      = 10;
    localparam int unsigned ENT_W        = 11;

    typedef struct packed {
        logic       brk;
        logic       frame;
        logic       par;
        logic [7:0] data;
    } rx_entry_t;

    // Number of data bits for a word-length code (00 -> 8 ... 11 -> 5).
    function automatic logic [3:0] wl_bits(input logic [1:0] wl);
        return 4'd8 - {2'b00, wl};
    endfunction

endpackage

// File: rtl/acia_fifo.sv
// Generic synchronous show-ahead FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module acia_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             BCLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage and pointers; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/acia_rx_ovs.sv
// ACIA receiver: synchronised, oversampled RX line with mid-bit 3-sample vote, framing,
// parity and break detection, feeding a status-tagged character FIFO.
module acia_rx_ovs
    import acia_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          BCLK,
    input  logic          RESET,
    input  logic          RX,
    input  logic [1:0]    R_WL,
    input  logic          R_PME,
    input  logic [1:0]    R_PMC,
    input  logic          RXPOP,
    output logic [7:0]    RXDATA,
    output logic          RXFRAME,
    output logic          RXPARITY,
    output logic          RXBREAK,
    output logic          RXEMPTY,
    output logic          RXFULL,
    output logic [CW-1:0] RXCOUNT,
    output logic          OVERFLOW,
    output logic          RXACTIVE
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned MID  = OVERSAMPLE / 2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_d;
    logic [OS_W-1:0]        cnt;
    logic                   smp_a;
    logic                   smp_b;
    logic                   tick_dec;
    logic                   vote;
    rx_state_t              state;
    rx_state_t              state_nxt;
    logic [2:0]             bit_idx;
    logic [7:0]             data_q;
    logic                   par_q;
    logic [1:0]             wl_q;
    logic                   pme_q;
    logic [1:0]             pmc_q;
    logic                   push_c;
    logic                   is_brk_c;
    logic                   par_err_c;
    logic                   last_bit_c;
    rx_entry_t              entry_c;
    rx_entry_t              head;
    logic [ENT_W-1:0]       fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;

    // Input synchroniser plus one extra flop for falling-edge detection; idle level is 1.
    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            sync_q <= '1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
            rx_d   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Bit-period counter free-runs through a frame; held at zero while waiting for an edge.
    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            cnt   <= '0;
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            if (state == IDLE || state == BRKWAIT) begin
                cnt <= '0;
            end else if (cnt == OS_W'(OVERSAMPLE - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + OS_W'(1);
            end
            if (cnt == OS_W'(MID - 1)) smp_a <= rx_s;
            if (cnt == OS_W'(MID))     smp_b <= rx_s;
        end
    end

    assign tick_dec   = (cnt == OS_W'(MID + 1));
    assign vote       = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign last_bit_c = ({1'b0, bit_idx} == (wl_bits(wl_q) - 4'd1));

    // Frame status derived from the held data/parity and the stop-bit vote.
    always_comb begin
        par_err_c = 1'b0;
        if (pme_q) begin
            if (pmc_q == PMC_ODD)  par_err_c = ~(^data_q ^ par_q);
            if (pmc_q == PMC_EVEN) par_err_c = ^data_q ^ par_q;
        end
        is_brk_c = (data_q == 8'h00) && (!pme_q || !par_q) && !vote;
        if (is_brk_c) begin
            entry_c = '{brk: 1'b1, frame: 1'b1, par: 1'b0, data: 8'h00};
        end else begin
            entry_c = '{brk: 1'b0, frame: ~vote, par: par_err_c, data: data_q};
        end
    end

    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_c    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) state_nxt = START;
            end
            START: begin
                if (tick_dec) state_nxt = vote ? IDLE : DATA;
            end
            DATA: begin
                if (tick_dec && last_bit_c) state_nxt = pme_q ? PARITY : STOP;
            end
            PARITY: begin
                if (tick_dec) state_nxt = STOP;
            end
            STOP: begin
                if (tick_dec) begin
                    push_c    = 1'b1;
                    state_nxt = is_brk_c ? BRKWAIT : IDLE;
                end
            end
            BRKWAIT: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame format is captured once the start bit is confirmed and held to the stop bit.
    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            wl_q    <= WL_8;
            pme_q   <= 1'b0;
            pmc_q   <= PMC_ODD;
            data_q  <= '0;
            par_q   <= 1'b0;
            bit_idx <= '0;
        end else if (tick_dec) begin
            if (state == START && !vote) begin
                wl_q    <= R_WL;
                pme_q   <= R_PME;
                pmc_q   <= R_PMC;
                data_q  <= '0;
                par_q   <= 1'b0;
                bit_idx <= '0;
            end else if (state == DATA) begin
                data_q[bit_idx] <= vote;
                bit_idx         <= bit_idx + 3'd1;
            end else if (state == PARITY) begin
                par_q <= vote;
            end
        end
    end

    // Sticky overflow: a dropped frame outranks a same-cycle pop.
    always_ff @(posedge BCLK or negedge RESET) begin
        if (!RESET) begin
            OVERFLOW <= 1'b0;
            RXACTIVE <= 1'b0;
        end else begin
            if (push_c && fifo_full && !RXPOP) begin
                OVERFLOW <= 1'b1;
            end else if (RXPOP) begin
                OVERFLOW <= 1'b0;
            end
            RXACTIVE <= !(state_nxt == IDLE || state_nxt == BRKWAIT);
        end
    end

    acia_fifo #(
        .WIDTH(ENT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .BCLK  (BCLK),
        .RESET (RESET),
        .push  (push_c),
        .pop   (RXPOP),
        .wdata (entry_c),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign head     = rx_entry_t'(fifo_rdata);
    assign RXDATA   = head.data;
    assign RXFRAME  = head.frame;
    assign RXPARITY = head.par;
    assign RXBREAK  = head.brk;
    assign RXEMPTY  = fifo_empty;
    assign RXFULL   = fifo_full;
    assign RXCOUNT  = fifo_count;

endmodule

// File: tb/tb_acia_rx_ovs.sv
// Directed bench for acia_rx_ovs: frames are built bit by bit, an entry queue models the
// FIFO, and a negedge process compares the DUT against it whenever the line is quiet.
module tb_acia_rx_ovs;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic       BCLK = 1'b0;
    logic       RESET = 1'b0;
    logic       RX = 1'b1;
    logic [1:0] R_WL = 2'b00;
    logic       R_PME = 1'b0;
    logic [1:0] R_PMC = 2'b00;
    logic       RXPOP = 1'b0;
    logic [7:0] RXDATA;
    logic       RXFRAME, RXPARITY, RXBREAK, RXEMPTY, RXFULL, OVERFLOW, RXACTIVE;
    logic [2:0] RXCOUNT;

    always #5 BCLK = ~BCLK;

    acia_rx_ovs #(
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .BCLK    (BCLK),
        .RESET   (RESET),
        .RX      (RX),
        .R_WL    (R_WL),
        .R_PME   (R_PME),
        .R_PMC   (R_PMC),
        .RXPOP   (RXPOP),
        .RXDATA  (RXDATA),
        .RXFRAME (RXFRAME),
        .RXPARITY(RXPARITY),
        .RXBREAK (RXBREAK),
        .RXEMPTY (RXEMPTY),
        .RXFULL  (RXFULL),
        .RXCOUNT (RXCOUNT),
        .OVERFLOW(OVERFLOW),
        .RXACTIVE(RXACTIVE)
    );

    // Model: entries are {break, frame, parity, data[7:0]}.
    logic [10:0] mq[$];
    bit          movf = 1'b0;
    bit          chk_en = 1'b0;

    int    n_cmp = 0;
    int    n_err = 0;
    string lit_name;
    int    lit_act, lit_exp;
    int    lit_req = 0;
    int    lit_ack = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Single compare process: hand-computed literals on request, model checks when quiet.
    initial begin
        logic [10:0] hd;
        forever begin
            @(negedge BCLK);
            if (lit_ack != lit_req) begin
                chk(lit_name, lit_act, lit_exp);
                lit_ack = lit_req;
            end
            if (chk_en) begin
                hd = (mq.size() > 0) ? mq[0] : 11'h000;
                chk("head", int'({RXBREAK, RXFRAME, RXPARITY, RXDATA}), int'(hd));
                chk("count", int'(RXCOUNT), mq.size());
                chk("empty", int'(RXEMPTY), int'(mq.size() == 0));
                chk("full", int'(RXFULL), int'(mq.size() == DEPTH));
                chk("overflow", int'(OVERFLOW), int'(movf));
                chk("active_idle", int'(RXACTIVE), 0);
            end
        end
    end

    task automatic lit(input string nm, input int act, input int exp);
        lit_name = nm;
        lit_act  = act;
        lit_exp  = exp;
        lit_req++;
        wait (lit_ack == lit_req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge BCLK);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        RX = v;
        tick(OS);
    endtask

    // One frame on the line; the expected entry follows from the frame contents alone.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input logic pme,
                              input logic [1:0] pmc, input logic bad_par, input logic stopv,
                              input int extra_low);
        int          n;
        int          ones;
        logic [7:0]  dm;
        logic        par;
        logic        perr;
        logic        brk;
        logic [10:0] ent;
        n    = 8 - int'(wl);
        dm   = d & (8'hFF >> wl);
        ones = $countones(dm);
        if (pmc == 2'b00)      par = (ones % 2 == 0);
        else if (pmc == 2'b01) par = (ones % 2 == 1);
        else                   par = 1'b0;
        if (bad_par) par = ~par;
        chk_en = 1'b0;
        R_WL = wl; R_PME = pme; R_PMC = pmc;
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(dm[i]);
        if (pme) drive_bit(par);
        drive_bit(stopv);
        perr = pme && ((pmc == 2'b00 && (ones + int'(par)) % 2 == 0) ||
                       (pmc == 2'b01 && (ones + int'(par)) % 2 == 1));
        brk  = (dm == 8'h00) && (!pme || !par) && !stopv;
        ent  = brk ? 11'h600 : {1'b0, ~stopv, perr, dm};
        if (mq.size() < DEPTH) mq.push_back(ent);
        else                   movf = 1'b1;
        if (extra_low > 0) begin
            RX = 1'b0;
            tick(extra_low * OS);
        end
        RX = 1'b1;
        tick(4);
        chk_en = 1'b1;
    endtask

    task automatic pop();
        RXPOP = 1'b1;
        tick(1);
        RXPOP = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        movf = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        RXPOP  = 1'b0;
        RX     = 1'b1;
        RESET  = 1'b0;
        tick(2);
        mq.delete();
        movf  = 1'b0;
        RESET = 1'b1;
        tick(3);
        chk_en = 1'b1;
    endtask

    initial begin
        tick(3);
        lit("rst_empty", int'(RXEMPTY), 1);
        lit("rst_outs", int'({RXDATA, RXFRAME, RXPARITY, RXBREAK, RXFULL, RXCOUNT, OVERFLOW, RXACTIVE}), 0);
        RESET = 1'b1;
        tick(3);
        chk_en = 1'b1;
        tick(5);

        // 8N1 0xA5
        send_frame(8'hA5, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 0);
        lit("a5_data", int'(RXDATA), 'hA5);
        lit("a5_flags", int'({RXBREAK, RXFRAME, RXPARITY}), 0);
        lit("a5_count", int'(RXCOUNT), 1);
        pop();
        lit("a5_popped_empty", int'(RXEMPTY), 1);

        // 7E1 0x41 with wrong parity bit
        send_frame(8'h41, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 0);
        lit("7e1_data", int'(RXDATA), 'h41);
        lit("7e1_parity", int'(RXPARITY), 1);
        pop();

        // 5-tick glitch on idle line
        chk_en = 1'b0;
        RX = 1'b0;
        tick(5);
        RX = 1'b1;
        tick(OS);
        chk_en = 1'b1;
        lit("glitch_active", int'(RXACTIVE), 0);
        lit("glitch_empty", int'(RXEMPTY), 1);

        // 5N1 0x15 with stop bit low
        send_frame(8'h15, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 0);
        lit("5n1_data", int'(RXDATA), 'h15);
        lit("5n1_frame", int'(RXFRAME), 1);
        pop();

        // Break: line low for three 8N1 frame times
        send_frame(8'h00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 20);
        lit("brk_flags", int'({RXBREAK, RXFRAME, RXPARITY, RXDATA}), 'h600);
        lit("brk_count", int'(RXCOUNT), 1);
        pop();

        // Fill with mixed formats, then overflow
        send_frame(8'h11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 0);
        send_frame(8'h22, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 0);
        send_frame(8'h33, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 0);
        send_frame(8'h0C, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 0);
        send_frame(8'h55, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 0);
        lit("ovf_set", int'(OVERFLOW), 1);
        lit("ovf_count", int'(RXCOUNT), 4);
        lit("ovf_head", int'({RXBREAK, RXFRAME, RXPARITY, RXDATA}), 'h011);
        pop();
        lit("ovf_cleared", int'(OVERFLOW), 0);
        lit("ovf_next_head", int'(RXDATA), 'h22);
        pop();
        lit("pmc1x_head", int'({RXBREAK, RXFRAME, RXPARITY, RXDATA}), 'h033);
        pop();
        pop();
        pop();
        lit("drained_count", int'(RXCOUNT), 0);

        // Reset in the middle of a frame
        send_frame(8'h99, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 0);
        chk_en = 1'b0;
        R_WL = 2'b00; R_PME = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        lit("mid_active", int'(RXACTIVE), 1);
        do_reset();
        lit("rst_mid_empty", int'(RXEMPTY), 1);
        lit("rst_mid_active", int'(RXACTIVE), 0);
        tick(5);
        send_frame(8'h3C, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 0);
        lit("post_rst_data", int'(RXDATA), 'h3C);
        pop();
        tick(5);
        chk_en = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
